md_sched: RTL

- Multiply/divide scheduler for the pipelined MIPS core.
- Sits beside the E stage and owns HI/LO.
- Accepts mult/div/mthi/mtlo issue from E and sequences the multi-cycle operation with a down-counter.
- Drives the `busy` bit carried in the pipeline message, plus a stall request for a decode-stage md-class instruction (mult/multu/div/divu/mfhi/mflo/mthi/mtlo).

---
 rtl/md_sched.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/md_sched.sv
`default_nettype none
// ============================================================================
// md_sched : MIPS multiply/divide scheduler owning HI/LO, with busy/stall.
// Revision : 1.0
// ============================================================================
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        cancel,
    input  logic        d_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_pend_hi;
    logic [31:0]   r_pend_lo;
    logic          r_pend_wr;

    logic          w_accept;
    logic [63:0]   w_smul;
    logic [63:0]   w_umul;
    logic          w_dsigned;
    logic [31:0]   w_a_mag;
    logic [31:0]   w_b_mag;
    logic [31:0]   w_b_safe;
    logic [31:0]   w_q_mag;
    logic [31:0]   w_r_mag;
    logic [31:0]   w_q;
    logic [31:0]   w_r;
    logic [31:0]   w_res_hi;
    logic [31:0]   w_res_lo;
    logic          w_res_wr;
    logic [CW-1:0] w_cycles;

    assign w_accept = start & ~cancel & (r_state == IDLE);
    assign stall    = d_md & (busy | start);

    assign w_smul = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    assign w_umul = {32'd0, rs} * {32'd0, rt};

    // Signed divide on magnitudes; this also yields 0x80000000 for INT_MIN / -1.
    assign w_dsigned = (op == OP_DIV);
    assign w_a_mag   = (w_dsigned & rs[31]) ? (~rs + 32'd1) : rs;
    assign w_b_mag   = (w_dsigned & rt[31]) ? (~rt + 32'd1) : rt;
    assign w_b_safe  = (rt == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag   = w_a_mag / w_b_safe;
    assign w_r_mag   = w_a_mag % w_b_safe;
    assign w_q       = (w_dsigned & (rs[31] ^ rt[31])) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_r       = (w_dsigned & rs[31]) ? (~w_r_mag + 32'd1) : w_r_mag;

    always_comb begin
        w_res_hi = w_smul[63:32];
        w_res_lo = w_smul[31:0];
        w_res_wr = 1'b1;
        w_cycles = MULT_CNT;
        case (op)
            OP_MULTU: begin
                w_res_hi = w_umul[63:32];
                w_res_lo = w_umul[31:0];
            end
            OP_DIV, OP_DIVU: begin
                w_res_hi = w_r;
                w_res_lo = w_q;
                w_res_wr = (rt != 32'd0);
                w_cycles = DIV_CNT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_wr <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                r_pend_hi <= w_res_hi;
                                r_pend_lo <= w_res_lo;
                                r_pend_wr <= w_res_wr;
                                r_cnt     <= w_cycles;
                                busy      <= 1'b1;
                                r_state   <= RUN;
                            end
                            OP_MTHI: hi <= rs;
                            OP_MTLO: lo <= rs;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (r_cnt == CNT_ONE) begin
                        if (r_pend_wr) begin
                            hi <= r_pend_hi;
                            lo <= r_pend_lo;
                        end
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
